// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Turns one raw, bouncy, asynchronous push-button pin into a clean debounced
// level plus single-cycle press/release pulses for the reaction-time
// benchmark core.
//
// The raw pin first passes through a SYNC_STAGES-deep synchroniser. A
// four-state FSM then accepts a new level only after the synchronised input
// has held that level for DEBOUNCE_CYCLES consecutive cycles. Every output is
// a register.
//
// Parameters
//   SYNC_STAGES     : synchroniser depth on btn_raw (>= 2)
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a level (>= 2)
//   CNT_W           : debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports
//   clk         in  system clock
//   rst         in  asynchronous reset, active low (0 = reset)
//   btn_raw     in  raw button pin, asynchronous, active high
//   en          in  1 = press/release pulses allowed, 0 = pulses suppressed
//   btn_level   out debounced button level
//   btn_press   out one-cycle pulse when the level is accepted as 1
//   btn_release out one-cycle pulse when the level is accepted as 0
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync;

    // The last synchroniser stage is the only view of the pin the FSM gets.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    assign sync   = sync_q[SYNC_STAGES-1];

    // Debounce FSM. The pulses default to 0 so each lasts exactly one cycle.
    // A WAIT state reverts to its IDLE state on any disagreeing sample, so a
    // bounce always restarts the count. The count is cleared on every state
    // entry and stops at CNT_LAST, so it never wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (sync) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = en;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!sync) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = en;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // State registers. Reset discards any pending debounce, and no pulse is
    // emitted for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with SYNC_STAGES=2 and
// DEBOUNCE_CYCLES=4. From the first edge that samples a new stable btn_raw
// value, the pulse appears after exactly 7 rising edges. Outputs are checked
// as the vector {btn_level, btn_press, btn_release}.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic en;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    int total = 0;
    int bad   = 0;

    button_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .en         (en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {level, press, release} against a hand-computed value.
    task automatic checkOutput(input string tag, input int step, input logic [2:0] expv);
        logic [2:0] obs;
        obs = {btn_level, btn_press, btn_release};
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s step %0d: observed=%b expected=%b", tag, step, obs, expv);
        end
    endtask

    // Drive the inputs for the next edge, clock it, then check the result.
    task automatic applyStimulus(input logic raw_v, input logic en_v, input string tag,
                                 input int step, input logic [2:0] expv);
        btn_raw = raw_v;
        en      = en_v;
        tick();
        checkOutput(tag, step, expv);
    endtask

    initial begin
        logic [5:0] bounce;
        logic [2:0] e;
        rst     = 1'b0;
        btn_raw = 1'b0;
        en      = 1'b1;
        #1;

        // 1: reset held while the pin toggles, then released with the pin low.
        for (int i = 1; i <= 6; i++) applyStimulus(i[0], 1'b1, "reset_hold", i, 3'b000);
        btn_raw = 1'b0;
        rst     = 1'b1;
        for (int i = 1; i <= 10; i++) applyStimulus(1'b0, 1'b1, "post_reset", i, 3'b000);

        // 2: clean press, held long with no auto-repeat, then clean release.
        for (int i = 1; i <= 30; i++) begin
            e = (i < 7) ? 3'b000 : (i == 7) ? 3'b110 : 3'b100;
            applyStimulus(1'b1, 1'b1, "press_hold", i, e);
        end
        for (int i = 1; i <= 10; i++) begin
            e = (i < 7) ? 3'b100 : (i == 7) ? 3'b001 : 3'b000;
            applyStimulus(1'b0, 1'b1, "release", i, e);
        end

        // 3: a 3-cycle pulse is rejected; a 5-cycle pulse is accepted both ways.
        for (int i = 1; i <= 15; i++) applyStimulus(i <= 3, 1'b1, "short_pulse", i, 3'b000);
        for (int i = 1; i <= 14; i++) begin
            e = (i < 7) ? 3'b000 : (i == 7) ? 3'b110 : (i < 12) ? 3'b100 :
                (i == 12) ? 3'b001 : 3'b000;
            applyStimulus(i <= 5, 1'b1, "five_pulse", i, e);
        end

        // 4: bounce 1,0,1,1,0,1 then stable 1; the final run starts at step 6.
        bounce = 6'b101101;
        for (int i = 1; i <= 20; i++) begin
            e = (i < 12) ? 3'b000 : (i == 12) ? 3'b110 : 3'b100;
            applyStimulus((i <= 6) ? bounce[6-i] : 1'b1, 1'b1, "bounce", i, e);
        end
        for (int i = 1; i <= 8; i++) begin
            e = (i < 7) ? 3'b100 : (i == 7) ? 3'b001 : 3'b000;
            applyStimulus(1'b0, 1'b1, "bounce_rel", i, e);
        end

        // 5a: en=0 at acceptance, so the level moves with no pulse.
        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b1, 1'b0, "en0_press", i, (i < 7) ? 3'b000 : 3'b100);
        // 5b: en=1 again, so the release pulse appears normally.
        for (int i = 1; i <= 8; i++) begin
            e = (i < 7) ? 3'b100 : (i == 7) ? 3'b001 : 3'b000;
            applyStimulus(1'b0, 1'b1, "en1_release", i, e);
        end
        // 5c: en low while debouncing but high on the acceptance edge.
        for (int i = 1; i <= 8; i++) begin
            e = (i < 7) ? 3'b000 : (i == 7) ? 3'b110 : 3'b100;
            applyStimulus(1'b1, i >= 7, "en_at_accept", i, e);
        end
        // 5d: en high while debouncing but low on the acceptance edge.
        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b0, i < 7, "en_drop", i, (i < 7) ? 3'b100 : 3'b000);
        en = 1'b1;

        // 6: reset in WAIT_HIGH with cnt=2, then the pin still high at release.
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, "to_wait", i, 3'b000);
        #2 rst = 1'b0;
        #1 checkOutput("rst_wait_async", 0, 3'b000);
        tick();
        checkOutput("rst_wait_held", 0, 3'b000);
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            e = (i < 7) ? 3'b000 : (i == 7) ? 3'b110 : 3'b100;
            applyStimulus(1'b1, 1'b1, "after_rst", i, e);
        end

        // Reset while the level is high must clear it without waiting for an edge.
        #2 rst = 1'b0;
        #1 checkOutput("rst_high_async", 0, 3'b000);
        tick();
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            e = (i < 7) ? 3'b000 : (i == 7) ? 3'b110 : 3'b100;
            applyStimulus(1'b1, 1'b1, "high_at_release", i, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
